// File: rtl/crp16_alu_arbiter_pkg.sv
// Shared definitions for the crp16 ALU arbiter: opcode codes, FSM states,
// and a small helper that turns a requester index into a one-hot vector.
package crp16_alu_arbiter_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR   = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU  = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_PASSY = 3'd7;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/crp16_alu_arbiter_rr_arb_2.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// when both request, the one named by prio_i wins.
module crp16_rr_arb_2
    import crp16_alu_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);

    // Pick the winner index, then expand it to a one-hot grant.
    always_comb begin
        win_o = 1'b0;
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
            2'b11:   win_o = prio_i;
            default: win_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            gnt_o = onehot2(win_o);
        end
    end

endmodule

// File: rtl/crp16_alu_arbiter.sv
// Shares one crp16 ALU between the execute stage (0) and the address/branch
// unit (1). One transaction at a time: accept, drive the ALU from registered
// operands for a cycle, capture the result and hold it until the owner takes it.
module crp16_alu_arbiter
    import crp16_alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    input  logic [WIDTH-1:0] req_x0,
    input  logic [WIDTH-1:0] req_x1,
    input  logic [WIDTH-1:0] req_y0,
    input  logic [WIDTH-1:0] req_y1,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_z,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [OP_W-1:0]  alu_op_q;
    logic [WIDTH-1:0] alu_x_q, alu_y_q, rsp_data_q;
    logic             load_op, load_rsp;
    logic [1:0]       gnt;
    logic             win;

    crp16_rr_arb_2 u_rr (
        .req_i  (req_valid),
        .prio_i (prio_q),
        .gnt_o  (gnt),
        .win_o  (win)
    );

    // Next-state, grant and load-enable decode for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;
        load_op     = 1'b0;
        load_rsp    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // The grant is nonzero only for a valid requester, so a grant is a handshake.
                req_ready = gnt;
                if (gnt != 2'b00) begin
                    load_op = 1'b1;
                    owner_d = win;
                    prio_d  = ~win;
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                load_rsp    = 1'b1;
                rsp_valid_d = onehot2(owner_q);
                state_d     = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ARB_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ARB_IDLE;
            end
        endcase
    end

    // Control state; reset discards any in-flight transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Operand and result registers load only on their enables, so no X leaks to the ALU.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_op_q   <= '0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (load_op) begin
                alu_op_q <= win ? req_op1 : req_op0;
                alu_x_q  <= win ? req_x1  : req_x0;
                alu_y_q  <= win ? req_y1  : req_y0;
            end
            if (load_rsp) begin
                rsp_data_q <= alu_z;
            end
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule
